// File: rtl/triangular_wave_analyzer.sv
// triangular_wave_analyzer
// Tracks a periodic 16-bit sample stream and recovers its peak, trough,
// peak-to-peak amplitude and period (in clk cycles). Turning points are
// declared once the sample moves more than HYST LSBs away from the running
// extreme; a measurement is published at every trough turn once a previous
// trough turn has been seen.
module triangular_wave_analyzer #(
    parameter int HYST  = 0,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             sample_valid,
    input  logic [15:0]      sample,
    output logic [15:0]      peak,
    output logic [15:0]      trough,
    output logic [15:0]      amplitude,
    output logic [CNT_W-1:0] period,
    output logic             meas_valid,
    output logic             rising,
    output logic             locked
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEEK    = 2'd1,
        RISING  = 2'd2,
        FALLING = 2'd3
    } state_t;

    // Hysteresis widened to 17 bits so that sample +/- HYST never wraps.
    localparam logic [16:0]      HYST17  = 17'(HYST);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    state_t           state_r;
    logic [15:0]      ext_r;
    logic [15:0]      peak_cand_r;
    logic [CNT_W-1:0] cyc_cnt_r;
    logic             have_trough_r;

    logic [16:0]      sample17_s;
    logic [16:0]      ext17_s;
    logic             above_s;
    logic             below_s;
    logic             peak_turn_s;
    logic             trough_turn_s;
    logic [CNT_W-1:0] cnt_next_s;

    // Turning-point comparisons in 17-bit unsigned and the saturating count.
    always_comb begin
        sample17_s    = {1'b0, sample};
        ext17_s       = {1'b0, ext_r};
        above_s       = sample17_s > (ext17_s + HYST17);
        below_s       = (sample17_s + HYST17) < ext17_s;
        // Only consulted after the strict new-extreme test has failed, so
        // the subtrahend never exceeds the minuend here.
        peak_turn_s   = (ext17_s - sample17_s) > HYST17;
        trough_turn_s = (sample17_s - ext17_s) > HYST17;
        if (cyc_cnt_r == CNT_MAX) begin
            cnt_next_s = CNT_MAX;
        end else begin
            cnt_next_s = cyc_cnt_r + CNT_ONE;
        end
    end

    // Measurement FSM: tracks extremes, counts the cycle and publishes results.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            ext_r         <= 16'd0;
            peak_cand_r   <= 16'd0;
            cyc_cnt_r     <= CNT_ZERO;
            have_trough_r <= 1'b0;
            peak          <= 16'd0;
            trough        <= 16'd0;
            amplitude     <= 16'd0;
            period        <= CNT_ZERO;
            meas_valid    <= 1'b0;
            rising        <= 1'b0;
            locked        <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (!ena) begin
                // Published values hold; tracking restarts from scratch.
                state_r       <= IDLE;
                cyc_cnt_r     <= CNT_ZERO;
                have_trough_r <= 1'b0;
                locked        <= 1'b0;
                rising        <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        cyc_cnt_r <= CNT_ZERO;
                        if (sample_valid) begin
                            ext_r   <= sample;
                            state_r <= SEEK;
                        end
                    end
                    SEEK: begin
                        cyc_cnt_r <= CNT_ZERO;
                        if (sample_valid) begin
                            if (above_s) begin
                                ext_r   <= sample;
                                state_r <= RISING;
                                rising  <= 1'b1;
                            end else if (below_s) begin
                                ext_r   <= sample;
                                state_r <= FALLING;
                            end
                        end
                    end
                    RISING: begin
                        cyc_cnt_r <= cnt_next_s;
                        if (sample_valid) begin
                            if (sample > ext_r) begin
                                ext_r <= sample;
                            end else if (peak_turn_s) begin
                                peak_cand_r <= ext_r;
                                ext_r       <= sample;
                                state_r     <= FALLING;
                                rising      <= 1'b0;
                            end
                        end
                    end
                    FALLING: begin
                        cyc_cnt_r <= cnt_next_s;
                        if (sample_valid) begin
                            if (sample < ext_r) begin
                                ext_r <= sample;
                            end else if (trough_turn_s) begin
                                // Trough turn: close the period and publish.
                                ext_r         <= sample;
                                state_r       <= RISING;
                                rising        <= 1'b1;
                                cyc_cnt_r     <= CNT_ZERO;
                                have_trough_r <= 1'b1;
                                if (have_trough_r) begin
                                    peak       <= peak_cand_r;
                                    trough     <= ext_r;
                                    amplitude  <= peak_cand_r - ext_r;
                                    period     <= cnt_next_s;
                                    meas_valid <= 1'b1;
                                    locked     <= 1'b1;
                                end
                            end
                        end
                    end
                    default: begin
                        state_r   <= IDLE;
                        cyc_cnt_r <= CNT_ZERO;
                        rising    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_triangular_wave_analyzer.sv
// Directed bench for triangular_wave_analyzer. Two instances share the
// stimulus: u0 with HYST=0 and u2 with HYST=2, each with its own enable.
// Expected publishes are queued when the triggering sample is driven and
// popped by a monitor when meas_valid is seen.
module tb_triangular_wave_analyzer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena0;
    logic        ena2;
    logic        sample_valid;
    logic [15:0] sample;

    logic [15:0] peak0, trough0, amp0, peak2, trough2, amp2;
    logic [31:0] period0, period2;
    logic        mv0, rising0, locked0, mv2, rising2, locked2;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] pk;
        logic [15:0] tr;
        logic [15:0] amp;
        logic [31:0] per;
    } exp_t;

    exp_t q0[$];
    exp_t q2[$];
    exp_t e0;
    exp_t e2;
    int   hs[$];

    triangular_wave_analyzer #(.HYST(0), .CNT_W(32)) u0 (
        .clk(clk), .rst_n(rst_n), .ena(ena0), .sample_valid(sample_valid),
        .sample(sample), .peak(peak0), .trough(trough0), .amplitude(amp0),
        .period(period0), .meas_valid(mv0), .rising(rising0), .locked(locked0)
    );

    triangular_wave_analyzer #(.HYST(2), .CNT_W(32)) u2 (
        .clk(clk), .rst_n(rst_n), .ena(ena2), .sample_valid(sample_valid),
        .sample(sample), .peak(peak2), .trough(trough2), .amplitude(amp2),
        .period(period2), .meas_valid(mv2), .rising(rising2), .locked(locked2)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] tri_v(input int i);
        int m;
        m = i % 8;
        return (m <= 4) ? 16'(m) : 16'(8 - m);
    endfunction

    function automatic exp_t mk(input int pk, input int tr, input int per);
        exp_t e;
        e.pk  = 16'(pk);
        e.tr  = 16'(tr);
        e.amp = 16'(pk - tr);
        e.per = 32'(per);
        return e;
    endfunction

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0; ena0 = 1'b0; ena2 = 1'b0; sample_valid = 1'b0; sample = 16'd0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor: every meas_valid pulse must match a queued entry.
    always @(negedge clk) begin
        if (mv0) begin
            chk("u0_pulse_expected", 32'(q0.size() != 0), 32'd1);
            if (q0.size() != 0) begin
                e0 = q0.pop_front();
                chk("u0_peak", 32'(peak0), 32'(e0.pk));
                chk("u0_trough", 32'(trough0), 32'(e0.tr));
                chk("u0_amplitude", 32'(amp0), 32'(e0.amp));
                chk("u0_period", period0, e0.per);
                chk("u0_locked", 32'(locked0), 32'd1);
            end
        end
        if (mv2) begin
            chk("u2_pulse_expected", 32'(q2.size() != 0), 32'd1);
            if (q2.size() != 0) begin
                e2 = q2.pop_front();
                chk("u2_peak", 32'(peak2), 32'(e2.pk));
                chk("u2_trough", 32'(trough2), 32'(e2.tr));
                chk("u2_amplitude", 32'(amp2), 32'(e2.amp));
                chk("u2_period", period2, e2.per);
            end
        end
    end

    initial begin
        rst_n = 1'b0; ena0 = 1'b0; ena2 = 1'b0; sample_valid = 1'b0; sample = 16'd0;
        repeat (2) @(negedge clk);
        // Reset state
        chk("rst_peak", 32'(peak0), 32'd0);
        chk("rst_trough", 32'(trough0), 32'd0);
        chk("rst_amplitude", 32'(amp0), 32'd0);
        chk("rst_period", period0, 32'd0);
        chk("rst_meas_valid", 32'(mv0), 32'd0);
        chk("rst_rising", 32'(rising0), 32'd0);
        chk("rst_locked", 32'(locked0), 32'd0);
        chk("rst_u2_locked", 32'(locked2), 32'd0);
        rst_n = 1'b1;

        // Clean triangle, HYST=0: publishes at sample 17, 25, 33.
        reset_dut();
        for (int i = 0; i <= 33; i++) begin
            @(negedge clk);
            if (i == 17) chk("tri_locked_before", 32'(locked0), 32'd0);
            if (i == 18) chk("tri_locked_after", 32'(locked0), 32'd1);
            ena0 = 1'b1; sample_valid = 1'b1; sample = tri_v(i);
            if (i >= 17 && (i - 17) % 8 == 0) q0.push_back(mk(4, 0, 8));
        end
        @(negedge clk);
        sample_valid = 1'b0;
        @(negedge clk);
        chk("tri_queue_drained", 32'(q0.size()), 32'd0);

        // Prescaled: one valid sample every 4th clk -> period 32.
        reset_dut();
        for (int i = 0; i <= 25; i++) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                ena0 = 1'b1; sample_valid = (c == 0); sample = tri_v(i);
                if (c == 0 && (i == 17 || i == 25)) q0.push_back(mk(4, 0, 32));
            end
        end
        @(negedge clk);
        sample_valid = 1'b0;
        chk("presc_queue_drained", 32'(q0.size()), 32'd0);

        // Plateau 0,1,2,2,2,1,0,0 (period 8): the 2,2,2 run never turns.
        reset_dut();
        for (int i = 0; i <= 25; i++) begin
            logic [15:0] pv;
            case (i % 8)
                2, 3, 4: pv = 16'd2;
                1, 5:    pv = 16'd1;
                default: pv = 16'd0;
            endcase
            @(negedge clk);
            if (i == 4 || i == 5) chk("plateau_rising", 32'(rising0), 32'd1);
            if (i == 6) chk("plateau_turned", 32'(rising0), 32'd0);
            ena0 = 1'b1; sample_valid = 1'b1; sample = pv;
            if (i == 17 || i == 25) q0.push_back(mk(2, 0, 8));
        end
        @(negedge clk);
        sample_valid = 1'b0;
        @(negedge clk);
        chk("plateau_queue_drained", 32'(q0.size()), 32'd0);

        // Hysteresis sequence: 10,2,5,6,7,6,7,8..20,17,10,5,8
        hs = '{10, 2, 5, 6, 7, 6, 7};
        for (int v = 8; v <= 20; v++) hs.push_back(v);
        hs.push_back(17); hs.push_back(10); hs.push_back(5); hs.push_back(8);

        // HYST=2 instance: the 7->6 dip is ignored, peak 20 published.
        reset_dut();
        for (int j = 0; j < hs.size(); j++) begin
            @(negedge clk);
            if (j == 6) chk("hyst2_dip_ignored", 32'(rising2), 32'd1);
            if (j == 21) chk("hyst2_turn_at_17", 32'(rising2), 32'd0);
            ena2 = 1'b1; sample_valid = 1'b1; sample = 16'(hs[j]);
            if (j == 23) q2.push_back(mk(20, 5, 21));
        end
        @(negedge clk);
        sample_valid = 1'b0;
        @(negedge clk);
        chk("hyst2_queue_drained", 32'(q2.size()), 32'd0);

        // HYST=0 instance: the dip produces a spurious peak of 7.
        reset_dut();
        for (int j = 0; j < hs.size(); j++) begin
            @(negedge clk);
            ena0 = 1'b1; sample_valid = 1'b1; sample = 16'(hs[j]);
            if (j == 6) q0.push_back(mk(7, 6, 4));
            if (j == 23) q0.push_back(mk(20, 5, 17));
        end
        @(negedge clk);
        sample_valid = 1'b0;
        @(negedge clk);
        chk("hyst0_queue_drained", 32'(q0.size()), 32'd0);

        // ena drop for 3 edges after lock.
        reset_dut();
        for (int i = 0; i <= 20; i++) begin
            @(negedge clk);
            ena0 = 1'b1; sample_valid = 1'b1; sample = tri_v(i);
            if (i == 17) q0.push_back(mk(4, 0, 8));
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 0) chk("ena_locked_before", 32'(locked0), 32'd1);
            if (k > 0) chk("ena_low_no_pulse", 32'(mv0), 32'd0);
            ena0 = 1'b0; sample_valid = 1'b1; sample = 16'd9;
        end
        for (int i = 21; i <= 33; i++) begin
            @(negedge clk);
            if (i == 21) begin
                chk("ena_locked_cleared", 32'(locked0), 32'd0);
                chk("ena_peak_hold", 32'(peak0), 32'd4);
                chk("ena_amp_hold", 32'(amp0), 32'd4);
                chk("ena_period_hold", period0, 32'd8);
            end
            if (i == 26) chk("ena_no_relock_first_trough", 32'(locked0), 32'd0);
            ena0 = 1'b1; sample_valid = 1'b1; sample = tri_v(i);
            if (i == 33) q0.push_back(mk(4, 0, 8));
        end
        @(negedge clk);
        sample_valid = 1'b0;
        @(negedge clk);
        chk("ena_queue_drained", 32'(q0.size()), 32'd0);
        chk("ena_relocked", 32'(locked0), 32'd1);

        // Synchronous reset while FALLING.
        reset_dut();
        for (int i = 0; i <= 22; i++) begin
            @(negedge clk);
            ena0 = 1'b1; sample_valid = 1'b1; sample = tri_v(i);
            if (i == 17) q0.push_back(mk(4, 0, 8));
        end
        @(negedge clk);
        sample_valid = 1'b0;
        chk("srst_pre_locked", 32'(locked0), 32'd1);
        chk("srst_pre_falling", 32'(rising0), 32'd0);
        // rst_n pulse that does not straddle a rising edge is ignored.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("glitch_locked", 32'(locked0), 32'd1);
        chk("glitch_peak", 32'(peak0), 32'd4);
        rst_n = 1'b0; sample_valid = 1'b1; sample = 16'd3;
        @(negedge clk);
        rst_n = 1'b1; sample_valid = 1'b0;
        chk("srst_peak", 32'(peak0), 32'd0);
        chk("srst_trough", 32'(trough0), 32'd0);
        chk("srst_amplitude", 32'(amp0), 32'd0);
        chk("srst_period", period0, 32'd0);
        chk("srst_meas_valid", 32'(mv0), 32'd0);
        chk("srst_rising", 32'(rising0), 32'd0);
        chk("srst_locked", 32'(locked0), 32'd0);
        chk("srst_queue_drained", 32'(q0.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
